// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch/button conditioning front end.
//   DEBOUNCE_10MS : default stability window, 10 ms at a 100 MHz clock.
//   SYNC_STAGES   : depth of the metastability synchroniser on every raw input.
package switch_debouncer_pkg;

  localparam int DEBOUNCE_10MS = 1000000;
  localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_bit.sv
// Purpose : synchronise one asynchronous input and accept a new level only after it is stable.
// Latency : a steady raw level appears on q exactly SYNC_STAGES+STABLE_CYCLES rising edges after first sampled.
// Ports   : clk, reset (async, active high), d_raw (async input), q (debounced level),
//           q_rise / q_change (strobes, high in the cycle whose closing edge loads a new q).
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic q,
  output logic q_rise,
  output logic q_change
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  assign s2 = sync[SYNC_STAGES-1];

  // The edge that would push the counter past its last value loads the new level instead,
  // so the counter never wraps.
  assign accept   = (s2 != q) && (cnt == CNT_MAX);
  assign q_change = accept;
  assign q_rise   = accept && s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_raw};
      if (s2 == q) begin
        // Any return to the accepted level (a glitch) restarts the window.
        cnt <= '0;
      end else if (accept) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Purpose : debounce W slide switches and one push button; toggle sel per press, flag sw updates.
// Latency : sw/sel follow a steady raw level after 2+STABLE_CYCLES edges; sw_changed one cycle after sw moves.
// Ports   : clk, reset (async, active high), sw_raw[W], btn_raw -> sw[W], sel, sw_changed.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int W             = 7,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_raw,
  input  logic         btn_raw,
  output logic [W-1:0] sw,
  output logic         sel,
  output logic         sw_changed
);

  // Bit W of the per-input vectors is the push button; bits W-1:0 are the switches.
  localparam logic [W:0] SW_MASK = {1'b0, {W{1'b1}}};

  logic [W:0] raw_all;
  logic [W:0] db_all;
  logic [W:0] rise_all;
  logic [W:0] chg_all;
  logic       btn_db;
  logic       btn_press;
  logic       sw_update;
  logic       upd_q;

  assign raw_all = {btn_raw, sw_raw};

  for (genvar i = 0; i <= W; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .d_raw    (raw_all[i]),
      .q        (db_all[i]),
      .q_rise   (rise_all[i]),
      .q_change (chg_all[i])
    );
  end

  assign sw     = db_all[W-1:0];
  assign btn_db = db_all[W];

  // Press strobe lines up with the edge that raises btn_db; release never toggles.
  assign btn_press = (|(rise_all & ~SW_MASK)) && !btn_db;
  // Several switches accepted on the same edge collapse into one update.
  assign sw_update = |(chg_all & SW_MASK);

  // upd_q is high in the first cycle sw shows its new value; sw_changed follows it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= 1'b0;
      upd_q      <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      if (btn_press) begin
        sel <= ~sel;
      end
      upd_q      <= sw_update;
      sw_changed <= upd_q;
    end
  end

endmodule
